// File: rtl/axi_native_responder.sv
// Word-addressed register bank behind a native AXI-network slave port, with independent
// write/read channels of programmable latency. Optional macro: RESPONDER_BUS_ERROR_EN.
module axi_native_responder #(
    parameter logic [31:0] BASE_ADDRESS  = 32'h0,
    parameter int          DEPTH         = 64,
    parameter int          WRITE_LATENCY = 1,
    parameter int          READ_LATENCY  = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        write_request_i,
    input  logic [31:0] write_address_i,
    input  logic [31:0] write_data_i,
    input  logic [3:0]  write_strobe_i,
    output logic        write_ready_o,
    output logic        write_busy_o,
    output logic        write_done_o,
    output logic        write_error_o,
    input  logic        read_request_i,
    input  logic [31:0] read_address_i,
    output logic        read_ready_o,
    output logic        read_busy_o,
    output logic        read_done_o,
    output logic [31:0] read_data_o,
    output logic        read_error_o
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [31:0] SPAN    = 32'(4 * DEPTH);
    localparam logic [3:0]  WR_WAIT = 4'(WRITE_LATENCY - 2);
    localparam logic [3:0]  RD_WAIT = 4'(READ_LATENCY - 2);
`ifdef RESPONDER_BUS_ERROR_EN
    localparam logic        ERR_EN  = 1'b1;
`else
    localparam logic        ERR_EN  = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    logic [31:0] mem_q [DEPTH];
    logic [31:0] mem_d [DEPTH];

    state_t      wr_state_q, wr_state_d;
    logic [3:0]  wr_cnt_q, wr_cnt_d;
    logic [AW-1:0] wr_idx_q, wr_idx_d;
    logic        wr_ok_q, wr_ok_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic [3:0]  wr_strb_q, wr_strb_d;
    logic        wr_ready_q, wr_ready_d, wr_busy_q, wr_busy_d;
    logic        wr_done_q, wr_done_d, wr_err_q, wr_err_d;

    state_t      rd_state_q, rd_state_d;
    logic [3:0]  rd_cnt_q, rd_cnt_d;
    logic        rd_ok_q, rd_ok_d;
    logic [31:0] rd_sample_q, rd_sample_d;
    logic        rd_ready_q, rd_ready_d, rd_busy_q, rd_busy_d;
    logic        rd_done_q, rd_done_d, rd_err_q, rd_err_d;
    logic [31:0] rd_rdata_q, rd_rdata_d;

    logic [31:0] wr_off, rd_off;
    logic        wr_ok_now, rd_ok_now;
    logic [AW-1:0] rd_idx;

    assign wr_off    = write_address_i - BASE_ADDRESS;
    assign rd_off    = read_address_i - BASE_ADDRESS;
    assign wr_ok_now = (write_address_i >= BASE_ADDRESS) && (wr_off < SPAN)
                       && (write_address_i[1:0] == 2'b00);
    assign rd_ok_now = (read_address_i >= BASE_ADDRESS) && (rd_off < SPAN)
                       && (read_address_i[1:0] == 2'b00);
    assign rd_idx    = rd_off[AW+1:2];

    // NOTE: every variable gets a default at the top of the block so no path infers a latch.
    always_comb begin
        wr_state_d = wr_state_q;
        wr_cnt_d   = wr_cnt_q;
        wr_idx_d   = wr_idx_q;
        wr_ok_d    = wr_ok_q;
        wr_data_d  = wr_data_q;
        wr_strb_d  = wr_strb_q;
        case (wr_state_q)
            S_IDLE: if (write_request_i) begin
                wr_idx_d   = wr_off[AW+1:2];
                wr_ok_d    = wr_ok_now;
                wr_data_d  = write_data_i;
                wr_strb_d  = write_strobe_i;
                wr_cnt_d   = WR_WAIT;
                wr_state_d = (WRITE_LATENCY == 1) ? S_DONE : S_WAIT;
            end
            S_WAIT: if (wr_cnt_q == 4'd0) wr_state_d = S_DONE;
                    else wr_cnt_d = wr_cnt_q - 4'd1;
            default: wr_state_d = S_IDLE;
        endcase
        wr_ready_d = (wr_state_d == S_IDLE);
        wr_busy_d  = !wr_ready_d;
        wr_done_d  = (wr_state_d == S_DONE);
        wr_err_d   = wr_done_d && !wr_ok_d && ERR_EN;

        // Commit lands at the end of DONE, so a read sampling the same edge sees the old word.
        mem_d = mem_q;
        if (wr_state_q == S_DONE && wr_ok_q) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_strb_q[b]) mem_d[wr_idx_q][8*b +: 8] = wr_data_q[8*b +: 8];
            end
        end
    end

    always_comb begin
        rd_state_d  = rd_state_q;
        rd_cnt_d    = rd_cnt_q;
        rd_ok_d     = rd_ok_q;
        rd_sample_d = rd_sample_q;
        case (rd_state_q)
            S_IDLE: if (read_request_i) begin
                rd_ok_d     = rd_ok_now;
                rd_sample_d = rd_ok_now ? mem_q[rd_idx] : 32'h0;
                rd_cnt_d    = RD_WAIT;
                rd_state_d  = (READ_LATENCY == 1) ? S_DONE : S_WAIT;
            end
            S_WAIT: if (rd_cnt_q == 4'd0) rd_state_d = S_DONE;
                    else rd_cnt_d = rd_cnt_q - 4'd1;
            default: rd_state_d = S_IDLE;
        endcase
        rd_ready_d = (rd_state_d == S_IDLE);
        rd_busy_d  = !rd_ready_d;
        rd_done_d  = (rd_state_d == S_DONE);
        rd_err_d   = rd_done_d && !rd_ok_d && ERR_EN;
        rd_rdata_d = rd_done_d ? rd_sample_d : 32'h0;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_state_q  <= S_IDLE;
            wr_cnt_q    <= '0;
            wr_idx_q    <= '0;
            wr_ok_q     <= 1'b0;
            wr_data_q   <= '0;
            wr_strb_q   <= '0;
            wr_ready_q  <= 1'b1;
            wr_busy_q   <= 1'b0;
            wr_done_q   <= 1'b0;
            wr_err_q    <= 1'b0;
            rd_state_q  <= S_IDLE;
            rd_cnt_q    <= '0;
            rd_ok_q     <= 1'b0;
            rd_sample_q <= '0;
            rd_ready_q  <= 1'b1;
            rd_busy_q   <= 1'b0;
            rd_done_q   <= 1'b0;
            rd_err_q    <= 1'b0;
            rd_rdata_q  <= '0;
            // NOTE: the store is cleared on reset, which rules out a RAM macro; it is flop-based by design.
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_state_q  <= wr_state_d;
            wr_cnt_q    <= wr_cnt_d;
            wr_idx_q    <= wr_idx_d;
            wr_ok_q     <= wr_ok_d;
            wr_data_q   <= wr_data_d;
            wr_strb_q   <= wr_strb_d;
            wr_ready_q  <= wr_ready_d;
            wr_busy_q   <= wr_busy_d;
            wr_done_q   <= wr_done_d;
            wr_err_q    <= wr_err_d;
            rd_state_q  <= rd_state_d;
            rd_cnt_q    <= rd_cnt_d;
            rd_ok_q     <= rd_ok_d;
            rd_sample_q <= rd_sample_d;
            rd_ready_q  <= rd_ready_d;
            rd_busy_q   <= rd_busy_d;
            rd_done_q   <= rd_done_d;
            rd_err_q    <= rd_err_d;
            rd_rdata_q  <= rd_rdata_d;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
        end
    end

    assign write_ready_o = wr_ready_q;
    assign write_busy_o  = wr_busy_q;
    assign write_done_o  = wr_done_q;
    assign write_error_o = wr_err_q;
    assign read_ready_o  = rd_ready_q;
    assign read_busy_o   = rd_busy_q;
    assign read_done_o   = rd_done_q;
    assign read_data_o   = rd_rdata_q;
    assign read_error_o  = rd_err_q;

endmodule
